// File: rtl/mult_share_sched.sv
// Two requesters share one pipelined multiplier. Each burst loads DEPTH operand pairs,
// waits DRAIN_CYC cycles, then routes the readback to the granted requester.
// Latency: the grant is made one cycle after vld. Backpressure: RDY_mult low or vld[gnt] low stalls the burst.
module mult_share_sched #(
  parameter int LOGDEPTH  = 6,
  parameter int WIDTH     = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       vld,
  input  logic [15:0]      op0_r0,
  input  logic [15:0]      op1_r0,
  input  logic [15:0]      op0_r1,
  input  logic [15:0]      op1_r1,
  output logic [1:0]       rdy,
  output logic             EN_mult,
  output logic [15:0]      mult_input0,
  output logic [15:0]      mult_input1,
  input  logic             RDY_mult,
  output logic             EN_blockRead,
  input  logic             VALID_memVal,
  input  logic [WIDTH-1:0] memVal_data,
  output logic [1:0]       res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       done
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, READ, DONE} state_t;

  localparam int DEPTH = 2 ** LOGDEPTH;
  localparam int CW    = LOGDEPTH + 1;
  localparam int DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? DW'(DRAIN_CYC - 1) : '0;

  state_t          state, state_n;
  logic            gnt, gnt_n;
  logic            last_win, last_win_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   res_cnt, res_cnt_n;
  logic [DW-1:0]   drain_cnt, drain_cnt_n;
  logic            rd_seen, rd_seen_n;
  logic            gnt_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_win  <= 1'b1;
      cnt       <= '0;
      res_cnt   <= '0;
      drain_cnt <= '0;
      rd_seen   <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      last_win  <= last_win_n;
      cnt       <= cnt_n;
      res_cnt   <= res_cnt_n;
      drain_cnt <= drain_cnt_n;
      rd_seen   <= rd_seen_n;
    end
  end

  assign gnt_vld = gnt ? vld[1] : vld[0];

  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    last_win_n   = last_win;
    cnt_n        = cnt;
    res_cnt_n    = res_cnt;
    drain_cnt_n  = drain_cnt;
    rd_seen_n    = rd_seen;
    rdy          = 2'b00;
    EN_mult      = 1'b0;
    mult_input0  = '0;
    mult_input1  = '0;
    EN_blockRead = 1'b0;
    res_valid    = 2'b00;
    res_data     = '0;
    done         = 2'b00;

    case (state)
      IDLE: begin
        if (vld != 2'b00) begin
          // On contention the requester that lost the previous round wins
          gnt_n   = (vld == 2'b11) ? ~last_win : vld[1];
          cnt_n   = '0;
          state_n = LOAD;
        end
      end

      LOAD: begin
        EN_mult     = gnt_vld & RDY_mult;
        rdy         = gnt ? {EN_mult, 1'b0} : {1'b0, EN_mult};
        mult_input0 = gnt ? op0_r1 : op0_r0;
        mult_input1 = gnt ? op1_r1 : op1_r0;
        if (EN_mult) begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == DEPTH_C) begin
            drain_cnt_n = '0;
            state_n     = (DRAIN_CYC == 0) ? READ : DRAIN;
          end
        end
      end

      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n = READ;
        end else begin
          drain_cnt_n = drain_cnt + 1'b1;
        end
      end

      READ: begin
        // The readback request stays high until the first word shows up
        EN_blockRead = ~rd_seen;
        res_valid    = gnt ? {VALID_memVal, 1'b0} : {1'b0, VALID_memVal};
        res_data     = memVal_data;
        if (VALID_memVal) begin
          rd_seen_n = 1'b1;
          res_cnt_n = res_cnt + 1'b1;
          if (res_cnt_n == DEPTH_C) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        done        = gnt ? 2'b10 : 2'b01;
        last_win_n  = gnt;
        cnt_n       = '0;
        res_cnt_n   = '0;
        drain_cnt_n = '0;
        rd_seen_n   = 1'b0;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Outputs are quiet while reset is held, even when it interrupts a burst
    if (rst) begin
      rdy          = 2'b00;
      EN_mult      = 1'b0;
      mult_input0  = '0;
      mult_input1  = '0;
      EN_blockRead = 1'b0;
      res_valid    = 2'b00;
      res_data     = '0;
      done         = 2'b00;
    end
  end

endmodule

// File: doc/mult_share_sched.md
MULT_SHARE_SCHED -- requirements
Module: mult_share_sched

Interface
REQ-001 Parameter LOGDEPTH, default 6, log2 of burst length; DEPTH = 2**LOGDEPTH operand pairs per burst.
REQ-002 Parameter WIDTH, default 16, result width.
REQ-003 Parameter DRAIN_CYC, default 4, idle cycles after the last operand so the multiplier pipeline finishes writing.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 vld  in  2  vld[i] high: requester i presents an operand pair.
REQ-007 op0_r0, op1_r0, op0_r1, op1_r1  in  16 each  operand pairs for requesters 0 and 1.
REQ-008 rdy  out  2  rdy[i] high: requester i's pair is accepted this cycle.
REQ-009 EN_mult  out  1  operand-pair strobe to the multiplier.
REQ-010 mult_input0, mult_input1  out  16 each  operands from the granted requester.
REQ-011 RDY_mult  in  1  multiplier can accept a pair.
REQ-012 EN_blockRead  out  1  request for a multiplier block readback.
REQ-013 VALID_memVal  in  1  readback word valid.
REQ-014 memVal_data  in  WIDTH  readback word.
REQ-015 res_valid  out  2  res_valid[i] high: res_data belongs to requester i.
REQ-016 res_data  out  WIDTH  forwarded readback word.
REQ-017 done  out  2  one-cycle pulse on done[i] when requester i's burst completes.

Function
REQ-018 States: IDLE, LOAD, DRAIN, READ, DONE, held in one registered state variable.
REQ-019 IDLE: a single vld[i] high sets gnt=i; both high sets gnt to the requester that did not win last; go to LOAD next cycle with cnt=0.
REQ-020 LOAD: EN_mult = vld[gnt] & RDY_mult, combinational.
REQ-021 LOAD: rdy[gnt] = EN_mult; rdy of the other requester stays 0.
REQ-022 LOAD: mult_input0/1 select op0/op1 of gnt; both are 0 in all other states.
REQ-023 Each accepted pair increments cnt (LOGDEPTH+1 bits).
REQ-024 vld[gnt] low or RDY_mult low in LOAD stalls the burst; cnt holds and there is no timeout.
REQ-025 When cnt reaches DEPTH, go to DRAIN; no further pairs are accepted.
REQ-026 DRAIN: wait exactly DRAIN_CYC cycles, then go to READ.
REQ-027 READ: EN_blockRead is high from READ entry until the cycle VALID_memVal is first seen high, inclusive; it is 0 in all other states.
REQ-028 READ: res_valid[gnt] = VALID_memVal and res_data = memVal_data, both combinational; the other res_valid bit stays 0.
REQ-029 READ: the result counter increments on each valid word.
REQ-030 READ: after DEPTH valid words, go to DONE.
REQ-031 VALID_memVal outside READ is ignored; res_valid stays 0 and res_data is 0.
REQ-032 DONE (one cycle): pulse done[gnt], record last-winner = gnt, clear counters, go to IDLE.
REQ-033 A vld rising during DRAIN, READ or DONE is not granted until IDLE.
REQ-034 Round-robin fairness: with both requesters continuously asserting vld, grants alternate 0,1,0,1...
REQ-035 rdy, EN_mult, res_valid and done are 0 in IDLE.

Reset
REQ-036 rst high, including mid-burst: next state IDLE, counters 0, gnt 0, last-winner 1 (requester 0 has priority), all outputs 0.
REQ-037 An in-flight burst aborted by rst produces no done pulse.

Verification
REQ-038 Requester 0 only, 64 pairs (k, k+1), RDY_mult always 1 -> 64 EN_mult strobes; EN_blockRead after 4 idle cycles; 64 res_valid[0] words echoed; done[0] pulsed once.
REQ-039 Both vld high from reset -> bursts granted in order 0, 1, 0; res_valid[1] never high during requester 0's burst.
REQ-040 RDY_mult low for 10 cycles at cnt=30, and vld[0] low 3 cycles at cnt=50 -> no strobes while stalled; exactly 64 total; DRAIN begins only after the 64th pair.
REQ-041 rst pulsed at result 20 of a READ -> IDLE next cycle; all outputs 0; no done pulse; the next burst starts with cnt=0 and requester 0 priority.
REQ-042 VALID_memVal pulsed high during IDLE and LOAD -> res_valid stays 00.
REQ-043 VALID_memVal delayed 7 cycles into READ -> EN_blockRead held high for all 8 cycles, then 0.
